// File: rtl/button_event_fsm.sv
// button_event_fsm
// Turns a debounced button level into press / short / long / auto-repeat
// event pulses, timing the hold with the shared 10 ms tick strobe.
// All event outputs are registered; pulses last exactly one clk cycle.
// dbg_state mirrors the current FSM state (0 IDLE, 1 PRESSED, 2 HELD).

module button_event_fsm #(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_level,
  input  logic       i_tick10ms,
  output logic       o_press,
  output logic       o_short,
  output logic       o_long,
  output logic       o_repeat,
  output logic       o_held,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  // Terminal counts: the counter runs 0..N-1, so it never needs to hold N.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic             lvl_q;
  logic             rise;
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             short_d;
  logic             long_d;
  logic             repeat_d;
  logic             held_d;

  // lvl_q resets to 1 so a button already down at reset must be released
  // before it can produce a press.
  assign rise      = i_level & ~lvl_q;
  assign dbg_state = state;

  // State, counter, edge history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q    <= 1'b1;
      state    <= S_IDLE;
      cnt      <= '0;
      o_press  <= 1'b0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_held   <= 1'b0;
    end else begin
      lvl_q    <= i_level;
      state    <= state_d;
      cnt      <= cnt_d;
      o_press  <= press_d;
      o_short  <= short_d;
      o_long   <= long_d;
      o_repeat <= repeat_d;
      o_held   <= held_d;
    end
  end

  // Next state and counter; release is checked before the tick so it wins.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end
      end
      S_PRESSED: begin
        if (!i_level) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (i_tick10ms) begin
          if (cnt == LONG_LAST) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_HELD: begin
        if (!i_level) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (i_tick10ms) begin
          if (cnt == REPEAT_LAST) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the event outputs, registered alongside the state.
  always_comb begin
    press_d  = (state == S_IDLE) && rise;
    short_d  = (state == S_PRESSED) && !i_level;
    long_d   = (state == S_PRESSED) && i_level && i_tick10ms && (cnt == LONG_LAST);
    repeat_d = (state == S_HELD) && i_level && i_tick10ms && (cnt == REPEAT_LAST);
    held_d   = (state_d == S_HELD);
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// tb_button_event_fsm
// Two instances share the same stimulus: dut_a with LONG=4/REPEAT=2 and
// dut_b with the minimum LONG=1/REPEAT=1. A tick-counting reference model
// predicts every output vector of both instances each cycle.

`timescale 1ns/1ps

module tb_button_event_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  logic rst = 1'b1;
  logic i_level = 1'b0;
  logic i_tick10ms = 1'b0;

  always #5 clk = ~clk;

  logic a_press, a_short, a_long, a_repeat, a_held;
  logic b_press, b_short, b_long, b_repeat, b_held;
  logic [1:0] a_dbg, b_dbg;

  button_event_fsm #(.LONG_TICKS(4), .REPEAT_TICKS(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .i_level(i_level), .i_tick10ms(i_tick10ms),
    .o_press(a_press), .o_short(a_short), .o_long(a_long),
    .o_repeat(a_repeat), .o_held(a_held), .dbg_state(a_dbg)
  );

  button_event_fsm #(.LONG_TICKS(1), .REPEAT_TICKS(1), .CNT_W(1)) dut_b (
    .clk(clk), .rst(rst), .i_level(i_level), .i_tick10ms(i_tick10ms),
    .o_press(b_press), .o_short(b_short), .o_long(b_long),
    .o_repeat(b_repeat), .o_held(b_held), .dbg_state(b_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model / scoreboard ----------------
  // Vector layout per instance: {press, short, long, repeat, held}.
  logic [9:0] exp_q[$];
  logic       m_prev;
  bit         m_pr[2];
  int         m_n[2];
  logic [4:0] m_e[2];
  logic       m_rise;

  function automatic int lt(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int rt(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Model: count ticks seen while held since the press; long at tick L,
  // repeat whenever (ticks - L) is a positive multiple of R.
  always @(posedge clk) begin
    if (rst) begin
      m_prev = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_pr[k] = 1'b0;
        m_n[k]  = 0;
      end
      exp_q.push_back('0);
    end else begin
      m_rise = i_level & ~m_prev;
      for (int k = 0; k < 2; k++) begin
        m_e[k] = '0;
        if (!m_pr[k]) begin
          if (m_rise) begin
            m_pr[k]   = 1'b1;
            m_n[k]    = 0;
            m_e[k][4] = 1'b1;
          end
        end else if (!i_level) begin
          if (m_n[k] < lt(k)) m_e[k][3] = 1'b1;
          m_pr[k] = 1'b0;
        end else if (i_tick10ms) begin
          m_n[k] = m_n[k] + 1;
          if (m_n[k] == lt(k)) m_e[k][2] = 1'b1;
          else if (m_n[k] > lt(k) && ((m_n[k] - lt(k)) % rt(k)) == 0) m_e[k][1] = 1'b1;
        end
        m_e[k][0] = m_pr[k] && (m_n[k] >= lt(k));
      end
      m_prev = i_level;
      exp_q.push_back({m_e[1], m_e[0]});
    end
  end

  // ---------------- driver tasks ----------------
  logic [1:0] stim_q[$];   // {level, tick}
  int         ph = 0;

  function automatic logic tk_next();
    logic t;
    t  = (ph == 9);
    ph = (ph + 1) % 10;
    return t;
  endfunction

  task automatic add_cycles(input int n, input logic lvl);
    for (int i = 0; i < n; i++) stim_q.push_back({lvl, tk_next()});
  endtask

  // Append cycles at level lvl until k ticks have been applied.
  task automatic add_until_ticks(input int k, input logic lvl);
    int   seen;
    logic t;
    seen = 0;
    while (seen < k) begin
      t = tk_next();
      stim_q.push_back({lvl, t});
      seen += int'(t);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic lvl, input logic tk,
                       output logic [9:0] act, output logic [9:0] exp);
    @(negedge clk);
    i_level    = lvl;
    i_tick10ms = tk;
    @(posedge clk);
    #1;
    act = {b_press, b_short, b_long, b_repeat, b_held,
           a_press, a_short, a_long, a_repeat, a_held};
    if (exp_q.size() == 0) exp = 'x;
    else exp = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] act, exp;
    logic [1:0] s;
    add_cycles(3, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp || act !== 10'd0) begin
        n_err++;
        $display("FAIL reset_outputs t=%0t dut=%b want=%b", $time, act, exp);
      end
    end
    n_vec++;
    if (a_dbg !== 2'd0 || b_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state a=%0d b=%0d want 0", a_dbg, b_dbg);
    end
    rst = 1'b0;
    add_cycles(4, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL idle_after_reset t=%0t dut=%b model=%b", $time, act, exp);
      end
    end
  endtask

  task automatic test_short_press();
    logic [9:0] act, exp;
    logic [1:0] s;
    int pa, sa, la, ha;
    pa = 0; sa = 0; la = 0; ha = 0;
    add_cycles(1, 1'b1);
    add_until_ticks(2, 1'b1);
    add_cycles(1 + $urandom_range(0, 3), 1'b1);
    add_cycles(6, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL short_press t=%0t dut=%b model=%b", $time, act, exp);
      end
      pa += int'(act[4]); sa += int'(act[3]); la += int'(act[2]); ha += int'(act[0]);
    end
    n_vec++;
    if (pa != 1 || sa != 1 || la != 0 || ha != 0) begin
      n_err++;
      $display("FAIL short_press_counts press=%0d short=%0d long=%0d held=%0d want 1 1 0 0",
               pa, sa, la, ha);
    end
  endtask

  task automatic test_long_repeat();
    logic [9:0] act, exp;
    logic [1:0] s;
    int pa, sa, la, ra, ha, lb, rb;
    pa = 0; sa = 0; la = 0; ra = 0; ha = 0; lb = 0; rb = 0;
    add_cycles(1, 1'b1);
    add_until_ticks(9, 1'b1);
    add_cycles(2, 1'b1);
    add_cycles(5, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL long_repeat t=%0t dut=%b model=%b", $time, act, exp);
      end
      pa += int'(act[4]); sa += int'(act[3]); la += int'(act[2]);
      ra += int'(act[1]); ha += int'(act[0]);
      lb += int'(act[7]); rb += int'(act[6]);
    end
    n_vec++;
    if (pa != 1 || sa != 0 || la != 1 || ra != 2 || ha == 0 || a_held !== 1'b0) begin
      n_err++;
      $display("FAIL long_repeat_counts_a press=%0d short=%0d long=%0d repeat=%0d held_cycles=%0d held_now=%b want 1 0 1 2 >0 0",
               pa, sa, la, ra, ha, a_held);
    end
    n_vec++;
    if (lb != 1 || rb != 8) begin
      n_err++;
      $display("FAIL min_param_counts_b long=%0d repeat=%0d want 1 8", lb, rb);
    end
  endtask

  task automatic test_release_on_tick();
    logic [9:0] act, exp;
    logic [1:0] s;
    int sa, la;
    sa = 0; la = 0;
    add_cycles(1, 1'b1);
    add_until_ticks(3, 1'b1);
    while (ph != 9) add_cycles(1, 1'b1);
    add_cycles(1, 1'b0);   // release lands on the fourth tick
    add_cycles(5, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL release_on_tick t=%0t dut=%b model=%b", $time, act, exp);
      end
      sa += int'(act[3]); la += int'(act[2]);
    end
    n_vec++;
    if (sa != 1 || la != 0) begin
      n_err++;
      $display("FAIL release_on_tick_counts short=%0d long=%0d want 1 0", sa, la);
    end
  endtask

  task automatic test_held_through_reset();
    logic [9:0] act, exp;
    logic [1:0] s;
    int pulses, pa;
    pulses = 0; pa = 0;
    rst = 1'b1;
    add_cycles(2, 1'b1);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL held_in_reset t=%0t dut=%b model=%b", $time, act, exp);
      end
    end
    rst = 1'b0;
    add_cycles(25, 1'b1);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL held_after_reset t=%0t dut=%b model=%b", $time, act, exp);
      end
      pulses += int'(act != 10'd0);
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL held_after_reset_quiet active_cycles=%0d want 0", pulses);
    end
    add_cycles(3, 1'b0);
    add_cycles(2, 1'b1);
    add_cycles(2, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL repress_after_reset t=%0t dut=%b model=%b", $time, act, exp);
      end
      pa += int'(act[4]);
    end
    n_vec++;
    if (pa != 1) begin
      n_err++;
      $display("FAIL repress_press_count press=%0d want 1", pa);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [9:0] act, exp;
    logic [1:0] s;
    int pulses;
    pulses = 0;
    add_cycles(1, 1'b1);
    add_until_ticks(5, 1'b1);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL enter_held t=%0t dut=%b model=%b", $time, act, exp);
      end
    end
    n_vec++;
    if (a_held !== 1'b1 || b_held !== 1'b1) begin
      n_err++;
      $display("FAIL held_before_reset a=%b b=%b want 1 1", a_held, b_held);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (a_held !== 1'b0 || b_held !== 1'b0 || a_dbg !== 2'd0 || b_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset held a=%b b=%b state a=%0d b=%0d want 0 0 0 0",
               a_held, b_held, a_dbg, b_dbg);
    end
    add_cycles(2, 1'b1);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL mid_hold_in_reset t=%0t dut=%b model=%b", $time, act, exp);
      end
    end
    rst = 1'b0;
    add_cycles(20, 1'b1);
    add_cycles(4, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL mid_hold_after_reset t=%0t dut=%b model=%b", $time, act, exp);
      end
      pulses += int'(act != 10'd0);
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL mid_hold_quiet active_cycles=%0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [9:0] act, exp;
    logic [1:0] s;
    logic       lvl;
    int         run;
    lvl = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lvl = ~lvl;
      run = $urandom_range(1, 30);
      for (int j = 0; j < run; j++) stim_q.push_back({lvl, logic'($urandom_range(0, 3) == 0)});
    end
    add_cycles(3, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      cycle(s[1], s[0], act, exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL random t=%0t dut=%b model=%b", $time, act, exp);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_on_tick();
    test_held_through_reset();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
